// File: rtl/axis_ft245_device_pkg.sv
// axis_ft245_device_pkg: shared packet size default and active-low bus levels
package axis_ft245_device_pkg;
  localparam int PKT_SIZE_DEF = 512;
  localparam logic BUS_ACT = 1'b0;
  localparam logic BUS_IDLE = 1'b1;
endpackage

// File: rtl/axis_ft245_device_sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FWFT fifo; push/din in, pop in, dout = head, count = occupancy
module sync_fifo_fwft #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/axis_ft245_device.sv
// axis_ft245_device: FT245 sync-fifo device model; s_axis -> usb_data_o/usb_empty, usb_data_i/usb_wrn -> packetized m_axis
module axis_ft245_device
  import axis_ft245_device_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int PKT_SIZE = PKT_SIZE_DEF
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  input  logic       usb_rdn,
  input  logic       usb_wrn,
  input  logic       usb_oen,
  input  logic       usb_siwun,
  output logic       usb_empty,
  output logic       usb_full,
  input  logic [7:0] usb_data_i,
  output logic [7:0] usb_data_o,
  output logic       usb_data_t,
  input  logic       stall_tx,
  output logic       err_bus
);
  localparam int RA = $clog2(RX_DEPTH);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int CW = $clog2(PKT_SIZE);
  logic [RA:0] rx_count, rx_next;
  logic [TA:0] tx_count, tx_next;
  logic [8:0] tx_head;
  logic [7:0] hold_d;
  logic [CW-1:0] pkt_cnt;
  logic hold_v, hold_last, siwun_q;
  logic rx_push, rx_pop, wr_acc, si_fire, new_last, tx_push, tx_pop;
  assign s_axis_tready = !areset && rx_count != (RA+1)'(RX_DEPTH);
  assign rx_push = s_axis_tvalid && s_axis_tready;
  assign rx_pop = usb_rdn == BUS_ACT && usb_data_t == BUS_ACT && !usb_empty;
  assign rx_next = rx_count + (RA+1)'(rx_push) - (RA+1)'(rx_pop);
  assign wr_acc = usb_wrn == BUS_ACT && !usb_full;
  assign si_fire = usb_siwun == BUS_ACT && siwun_q == BUS_IDLE;
  assign new_last = pkt_cnt == CW'(PKT_SIZE - 1) || si_fire;
  // the held byte leaves when displaced by a new byte, when it closed a packet, or on a send-immediate
  assign tx_push = hold_v && (hold_last || wr_acc || si_fire);
  assign tx_pop = m_axis_tvalid && m_axis_tready;
  assign tx_next = tx_count + (TA+1)'(tx_push) - (TA+1)'(tx_pop);
  assign m_axis_tvalid = tx_count != '0;
  assign {m_axis_tlast, m_axis_tdata} = tx_head;
  sync_fifo_fwft #(.W(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk(aclk), .rst(areset), .push(rx_push), .din(s_axis_tdata),
    .pop(rx_pop), .dout(usb_data_o), .count(rx_count)
  );
  // with write+siwun on one edge the new byte carries tlast, so the displaced byte does not
  sync_fifo_fwft #(.W(9), .DEPTH(TX_DEPTH)) u_tx (
    .clk(aclk), .rst(areset), .push(tx_push),
    .din({hold_last || (si_fire && !wr_acc), hold_d}),
    .pop(tx_pop), .dout(tx_head), .count(tx_count)
  );
  always_ff @(posedge aclk) begin
    if (areset) begin
      usb_data_t <= 1'b1;
      usb_empty <= 1'b1;
      usb_full <= 1'b1;
      err_bus <= 1'b0;
      siwun_q <= BUS_IDLE;
      hold_v <= 1'b0;
      hold_last <= 1'b0;
      hold_d <= '0;
      pkt_cnt <= '0;
    end else begin
      usb_data_t <= usb_oen;
      usb_empty <= rx_next == '0;
      // one slot of slack absorbs the hold-register flush after full rises
      usb_full <= stall_tx || tx_next >= (TA+1)'(TX_DEPTH - 1);
      err_bus <= err_bus || (usb_oen == BUS_ACT && usb_wrn == BUS_ACT);
      siwun_q <= usb_siwun;
      if (wr_acc) begin
        hold_v <= 1'b1;
        hold_d <= usb_data_i;
        hold_last <= new_last;
        pkt_cnt <= new_last ? '0 : pkt_cnt + CW'(1);
      end else begin
        if (tx_push) hold_v <= 1'b0;
        if (si_fire) pkt_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axis_ft245_device.sv
// tb_axis_ft245_device: randomized bench against a queue-based model of the rx fifo and the packetized tx stream
module tb_axis_ft245_device;
  localparam int PKT = 512;
  logic aclk = 1'b0, areset = 1'b1;
  logic [7:0] s_axis_tdata = '0, m_axis_tdata, usb_data_i = '0, usb_data_o;
  logic s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
  logic usb_rdn = 1'b1, usb_wrn = 1'b1, usb_oen = 1'b1, usb_siwun = 1'b1;
  logic usb_empty, usb_full, usb_data_t, stall_tx = 1'b0, err_bus;
  int errors = 0, checks = 0, nout = 0, nlast = 0, pkt_len = 0;
  logic [7:0] rxq[$];
  logic [8:0] expq[$];
  logic [8:0] last_out = '0, held_v = '0;
  logic held = 1'b0, si_prev = 1'b1, full_seen = 1'b0;

  axis_ft245_device dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_oen(usb_oen),
    .usb_siwun(usb_siwun), .usb_empty(usb_empty), .usb_full(usb_full), .usb_data_i(usb_data_i),
    .usb_data_o(usb_data_o), .usb_data_t(usb_data_t), .stall_tx(stall_tx), .err_bus(err_bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    if (areset) held = 1'b0;
    else begin
      if (held) check("tx_stable", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({1'b1, held_v}));
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) check("tx_extra_valid", 32'(m_axis_tvalid), 0);
        else begin
          check("tx_byte", 32'({m_axis_tlast, m_axis_tdata}), 32'(expq.pop_front()));
          nout++;
          nlast += int'(m_axis_tlast);
          last_out = {m_axis_tlast, m_axis_tdata};
        end
      end
      held = m_axis_tvalid && !m_axis_tready;
      held_v = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic rx_cycle(input logic v, input logic [7:0] d, input logic rd, output logic popped);
    s_axis_tvalid = v;
    s_axis_tdata = d;
    usb_rdn = rd;
    check("rx_ready", 32'(s_axis_tready), 32'(rxq.size() < 16));
    popped = !rd && !usb_empty && !usb_data_t;
    if (popped) check("rx_data", 32'(usb_data_o), 32'(rxq.pop_front()));
    if (v && s_axis_tready) rxq.push_back(d);
    step();
    check("rx_empty", 32'(usb_empty), 32'(rxq.size() == 0));
  endtask

  task automatic tx_cycle(input logic wr, input logic [7:0] d, input logic si, input logic rdy, input logic st, output logic acc);
    logic fire, lst;
    usb_wrn = wr;
    usb_data_i = d;
    usb_siwun = si;
    m_axis_tready = rdy;
    stall_tx = st;
    acc = !wr && !usb_full;
    fire = !si && si_prev;
    si_prev = si;
    if (usb_full) full_seen = 1'b1;
    if (acc) begin
      pkt_len++;
      lst = pkt_len == PKT || fire;
      expq.push_back({lst, d});
      if (lst) pkt_len = 0;
    end else if (fire && pkt_len > 0) begin
      expq[expq.size()-1][8] = 1'b1;
      pkt_len = 0;
    end
    step();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tx_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, acc);
  endtask

  task automatic flush();
    logic acc;
    tx_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, acc);
    tx_cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    idle(20);
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    int a = 0;
    logic acc;
    for (int c = 0; c < n * 4 + 50 && a < n; c++) begin
      tx_cycle(1'b0, base + 8'(a), 1'b1, 1'b1, 1'b0, acc);
      if (acc) a++;
    end
    check("wr_done", a, n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"}, 32'(usb_empty), 1);
    check({tag, "_full"}, 32'(usb_full), 1);
    check({tag, "_data_t"}, 32'(usb_data_t), 1);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 0);
    check({tag, "_err"}, 32'(err_bus), 0);
    check({tag, "_sready"}, 32'(s_axis_tready), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int pops, n0, nl0, a, first_full;
    logic p, acc;
    #1;
    repeat (3) step();
    check_reset_vals("rst");
    areset = 1'b0;
    step();
    check("full_release", 32'(usb_full), 0);
    // rx: five directed bytes, then a core read burst that must stop at five
    for (int i = 0; i < 5; i++) rx_cycle(1'b1, 8'(i + 1), 1'b1, p);
    s_axis_tvalid = 1'b0;
    usb_oen = 1'b0;
    step();
    check("rx_oe", 32'(usb_data_t), 0);
    pops = 0;
    for (int i = 0; i < 9; i++) begin
      rx_cycle(1'b0, 8'h00, 1'b0, p);
      if (p) pops++;
    end
    check("rx_pops", pops, 5);
    for (int i = 0; i < 200; i++) rx_cycle(1'($urandom % 2), 8'($urandom), 1'($urandom % 3 == 0), p);
    for (int i = 0; i < 40 && rxq.size() > 0; i++) rx_cycle(1'b0, 8'h00, 1'b0, p);
    check("rx_drained", rxq.size(), 0);
    usb_rdn = 1'b1;
    usb_oen = 1'b1;
    step();
    // tx: one full packet streamed with the sink always ready
    full_seen = 1'b0;
    n0 = nout;
    write_bytes(PKT, 8'h00);
    idle(10);
    check("pkt_full_seen", 32'(full_seen), 0);
    check("pkt_count", nout - n0, PKT);
    check("pkt_last", 32'(last_out), 32'(9'h1FF));
    check("pkt_nlast", nlast, 1);
    // send-immediate closes a short packet exactly once
    n0 = nout;
    write_bytes(3, 8'hA0);
    idle(3);
    for (int i = 0; i < 4; i++) tx_cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    idle(10);
    check("si_count", nout - n0, 3);
    check("si_last", 32'(last_out), 32'(9'h1A2));
    check("si_nlast", nlast, 2);
    // backpressure: full must rise before more than TX_DEPTH bytes are taken
    a = 0;
    first_full = -1;
    for (int c = 0; c < 24; c++) begin
      if (usb_full && first_full < 0) first_full = a;
      tx_cycle(1'b0, 8'h40 + 8'(a), 1'b1, 1'b0, 1'b0, acc);
      if (acc) a++;
    end
    check("bp_full", 32'(usb_full), 1);
    check("bp_full_within", 32'(first_full > 0 && first_full <= 16), 1);
    for (int c = 0; c < 300; c++)
      tx_cycle(1'($urandom % 4 == 0), 8'($urandom), 1'($urandom % 16 != 0), 1'($urandom % 2), 1'($urandom % 20 == 0), acc);
    flush();
    check("bp_drained", expq.size(), 0);
    check("stall_pre", 32'(usb_full), 0);
    tx_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, acc);
    check("stall_full", 32'(usb_full), 1);
    tx_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, acc);
    check("stall_release", 32'(usb_full), 0);
    // bus contention is flagged and sticky
    check("err_pre", 32'(err_bus), 0);
    usb_oen = 1'b0;
    tx_cycle(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, acc);
    usb_oen = 1'b1;
    check("err_set", 32'(err_bus), 1);
    idle(3);
    check("err_sticky", 32'(err_bus), 1);
    flush();
    check("err_drained", expq.size(), 0);
    // reset mid-packet drops the partial packet; the next packet counts from zero
    write_bytes(100, 8'h10);
    areset = 1'b1;
    expq.delete();
    pkt_len = 0;
    si_prev = 1'b1;
    step();
    step();
    check_reset_vals("mid_rst");
    areset = 1'b0;
    usb_wrn = 1'b1;
    step();
    n0 = nout;
    nl0 = nlast;
    write_bytes(PKT, 8'h00);
    idle(10);
    check("rst_pkt_count", nout - n0, PKT);
    check("rst_pkt_nlast", nlast - nl0, 1);
    check("rst_pkt_last", 32'(last_out), 32'(9'h1FF));
    check("rst_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
